// File: rtl/miso_cal_pkg.sv
// MISO phase calibrator shared definitions: FSM state encoding, phase width,
// default phase count and the word comparison used by the frame check.
// Latency: none (types and a pure function). Backpressure: not applicable.
// Config macro: PHASE_CAL_DUALWORD_EN selects a full 32-bit compare (both
// DDR chips); when undefined only chip B ([15:0]) is compared.
package miso_cal_pkg;

    localparam int PHASE_W        = 4;
    localparam int DEF_NUM_PHASES = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_REQ,
        ST_CHECK,
        ST_NEXT,
        ST_EVAL,
        ST_DONE
    } cal_state_e;

    // True when the captured MISO word matches the known register contents.
    function automatic logic word_match(input logic [31:0] got,
                                        input logic [31:0] want);
`ifdef PHASE_CAL_DUALWORD_EN
        return got == want;
`else
        return got[15:0] == want[15:0];
`endif
    endfunction

endpackage

// File: rtl/miso_cal_window_finder.sv
// Bit-serial scan of the pass map for the longest run of passing phases.
// Latency: result/found/done are combinational on the final bit; state is
// registered per bit. Backpressure: none, one bit accepted whenever bit_vld_i.
// Ports: start_i clears the scan; bit_vld_i/bit_i deliver pass_map[0..N-1]
// in order; done_o marks the last bit; result_o = centre of best run
// (lower centre for even lengths), found_o = at least one passing phase.
module miso_cal_window_finder
    import miso_cal_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES
) (
    input  logic               dataclk_i,
    input  logic               reset_n_i,
    input  logic               start_i,
    input  logic               bit_vld_i,
    input  logic               bit_i,
    output logic               done_o,
    output logic               found_o,
    output logic [PHASE_W-1:0] result_o
);

    localparam int LEN_W = PHASE_W + 1;
    localparam logic [PHASE_W-1:0] IDX_ONE  = PHASE_W'(1);
    localparam logic [PHASE_W-1:0] IDX_LAST = PHASE_W'(NUM_PHASES - 1);
    localparam logic [LEN_W-1:0]   LEN_ONE  = LEN_W'(1);

    logic [PHASE_W-1:0] idx_q, idx_d;
    logic [PHASE_W-1:0] cur_start_q, cur_start_d;
    logic [PHASE_W-1:0] best_start_q, best_start_d;
    logic [LEN_W-1:0]   cur_len_q, cur_len_d;
    logic [LEN_W-1:0]   best_len_q, best_len_d;

    always_comb begin
        idx_d        = idx_q;
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        if (start_i) begin
            idx_d        = '0;
            cur_start_d  = '0;
            cur_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (bit_vld_i) begin
            idx_d = idx_q + IDX_ONE;
            if (bit_i) begin
                if (cur_len_q == '0) begin
                    cur_start_d = idx_q;
                end
                cur_len_d = cur_len_q + LEN_ONE;
                // Strictly longer only: an equal-length later run never
                // displaces the earlier one, so ties keep the lowest index.
                if (cur_len_d > best_len_q) begin
                    best_len_d   = cur_len_d;
                    best_start_d = cur_start_d;
                end
            end else begin
                cur_len_d = '0;
            end
        end
    end

    // Outputs look at the next-state values so the final bit is included
    // in the cycle done_o is raised.
    assign done_o   = bit_vld_i && (idx_q == IDX_LAST);
    assign found_o  = (best_len_d != '0);
    assign result_o = PHASE_W'({1'b0, best_start_d} + ((best_len_d - LEN_ONE) >> 1));

    always_ff @(posedge dataclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idx_q        <= '0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            idx_q        <= idx_d;
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

endmodule

// File: rtl/miso_phase_calibrator.sv
// Sweeps MISO sampling phases, checks known-register frames at each, and
// picks the centre of the widest passing window. Latency: one sweep per
// cal_start; phase_select registered one cycle. Backpressure: frame_req_o
// held until frame_ack_i; cal_start_i ignored while busy.
// Ports: dataclk_i/reset_n_i (async active-low); cal_start_i pulse;
// auto_mode_i/manual_phase_i choose the idle phase; frame_req_o/frame_ack_i
// handshake with miso_word_i vs expected_word_i; phase_select_o;
// busy_o/cal_done_o/cal_fail_o status; pass_map_o per-phase results.
// Config macro: PHASE_CAL_DUALWORD_EN (full 32-bit compare when defined).
module miso_phase_calibrator
    import miso_cal_pkg::*;
#(
    parameter int NUM_PHASES       = DEF_NUM_PHASES,
    parameter int FRAMES_PER_PHASE = 8,
    parameter int SETTLE_CYCLES    = 4
) (
    input  logic                  dataclk_i,
    input  logic                  reset_n_i,
    input  logic                  cal_start_i,
    input  logic                  auto_mode_i,
    input  logic [PHASE_W-1:0]    manual_phase_i,
    output logic                  frame_req_o,
    input  logic                  frame_ack_i,
    input  logic [31:0]           miso_word_i,
    input  logic [31:0]           expected_word_i,
    output logic [PHASE_W-1:0]    phase_select_o,
    output logic                  busy_o,
    output logic                  cal_done_o,
    output logic                  cal_fail_o,
    output logic [NUM_PHASES-1:0] pass_map_o
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int FRM_W = $clog2(FRAMES_PER_PHASE + 1);
    localparam logic [SET_W-1:0]   SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SET_W-1:0]   SET_ONE  = SET_W'(1);
    localparam logic [FRM_W-1:0]   FRM_LAST = FRM_W'(FRAMES_PER_PHASE - 1);
    localparam logic [FRM_W-1:0]   FRM_ONE  = FRM_W'(1);
    localparam logic [PHASE_W-1:0] PH_LAST  = PHASE_W'(NUM_PHASES - 1);
    localparam logic [PHASE_W-1:0] PH_ONE   = PHASE_W'(1);

    cal_state_e            state_q, state_d;
    logic [PHASE_W-1:0]    phase_cnt_q, phase_cnt_d;
    logic [SET_W-1:0]      settle_cnt_q, settle_cnt_d;
    logic [FRM_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic [PHASE_W-1:0]    eval_cnt_q, eval_cnt_d;
    logic                  pass_flag_q, pass_flag_d;
    logic [31:0]           word_q, word_d;
    logic [NUM_PHASES-1:0] pass_map_q, pass_map_d;
    logic [PHASE_W-1:0]    cal_phase_q, cal_phase_d;
    logic [PHASE_W-1:0]    phase_select_q, phase_select_d;
    logic                  frame_req_q, frame_req_d;
    logic                  busy_q, busy_d;
    logic                  cal_done_q, cal_done_d;
    logic                  cal_fail_q, cal_fail_d;

    logic                  win_start;
    logic                  win_bit_vld;
    logic                  win_done;
    logic                  win_found;
    logic [PHASE_W-1:0]    win_result;

    miso_cal_window_finder #(
        .NUM_PHASES (NUM_PHASES)
    ) u_window (
        .dataclk_i (dataclk_i),
        .reset_n_i (reset_n_i),
        .start_i   (win_start),
        .bit_vld_i (win_bit_vld),
        .bit_i     (pass_map_q[eval_cnt_q]),
        .done_o    (win_done),
        .found_o   (win_found),
        .result_o  (win_result)
    );

    always_comb begin
        state_d      = state_q;
        phase_cnt_d  = phase_cnt_q;
        settle_cnt_d = settle_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        eval_cnt_d   = eval_cnt_q;
        pass_flag_d  = pass_flag_q;
        word_d       = word_q;
        pass_map_d   = pass_map_q;
        cal_phase_d  = cal_phase_q;
        busy_d       = busy_q;
        cal_done_d   = cal_done_q;
        cal_fail_d   = cal_fail_q;
        win_start    = 1'b0;
        win_bit_vld  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cal_start_i) begin
                    state_d      = ST_SETTLE;
                    busy_d       = 1'b1;
                    cal_done_d   = 1'b0;
                    cal_fail_d   = 1'b0;
                    pass_map_d   = '0;
                    phase_cnt_d  = '0;
                    settle_cnt_d = '0;
                    pass_flag_d  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SET_LAST) begin
                    settle_cnt_d = '0;
                    state_d      = ST_REQ;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_ONE;
                end
            end
            ST_REQ: begin
                if (frame_ack_i) begin
                    word_d  = miso_word_i;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Sticky fail: one bad frame disqualifies the whole phase.
                if (!word_match(word_q, expected_word_i)) begin
                    pass_flag_d = 1'b0;
                end
                if (frame_cnt_q == FRM_LAST) begin
                    frame_cnt_d = '0;
                    state_d     = ST_NEXT;
                end else begin
                    frame_cnt_d = frame_cnt_q + FRM_ONE;
                    state_d     = ST_REQ;
                end
            end
            ST_NEXT: begin
                pass_map_d[phase_cnt_q] = pass_flag_q;
                if (phase_cnt_q == PH_LAST) begin
                    eval_cnt_d = '0;
                    win_start  = 1'b1;
                    state_d    = ST_EVAL;
                end else begin
                    phase_cnt_d  = phase_cnt_q + PH_ONE;
                    settle_cnt_d = '0;
                    pass_flag_d  = 1'b1;
                    state_d      = ST_SETTLE;
                end
            end
            ST_EVAL: begin
                win_bit_vld = 1'b1;
                eval_cnt_d  = eval_cnt_q + PH_ONE;
                if (win_done) begin
                    eval_cnt_d  = '0;
                    phase_cnt_d = '0;
                    busy_d      = 1'b0;
                    cal_done_d  = 1'b1;
                    state_d     = ST_DONE;
                    if (win_found) begin
                        cal_phase_d = win_result;
                    end else begin
                        cal_fail_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        frame_req_d = (state_d == ST_REQ);

        // Next-state sources keep phase_select aligned with busy and with a
        // freshly stored calibration result.
        if (busy_d) begin
            phase_select_d = phase_cnt_d;
        end else if (auto_mode_i) begin
            phase_select_d = cal_phase_d;
        end else begin
            phase_select_d = manual_phase_i;
        end
    end

    always_ff @(posedge dataclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= ST_IDLE;
            phase_cnt_q    <= '0;
            settle_cnt_q   <= '0;
            frame_cnt_q    <= '0;
            eval_cnt_q     <= '0;
            pass_flag_q    <= 1'b0;
            word_q         <= '0;
            pass_map_q     <= '0;
            cal_phase_q    <= '0;
            phase_select_q <= '0;
            frame_req_q    <= 1'b0;
            busy_q         <= 1'b0;
            cal_done_q     <= 1'b0;
            cal_fail_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_cnt_q    <= phase_cnt_d;
            settle_cnt_q   <= settle_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            eval_cnt_q     <= eval_cnt_d;
            pass_flag_q    <= pass_flag_d;
            word_q         <= word_d;
            pass_map_q     <= pass_map_d;
            cal_phase_q    <= cal_phase_d;
            phase_select_q <= phase_select_d;
            frame_req_q    <= frame_req_d;
            busy_q         <= busy_d;
            cal_done_q     <= cal_done_d;
            cal_fail_q     <= cal_fail_d;
        end
    end

    assign frame_req_o    = frame_req_q;
    assign phase_select_o = phase_select_q;
    assign busy_o         = busy_q;
    assign cal_done_o     = cal_done_q;
    assign cal_fail_o     = cal_fail_q;
    assign pass_map_o     = pass_map_q;

endmodule

// File: tb/tb_miso_phase_calibrator.sv
// Self-checking bench for miso_phase_calibrator: a frame sequencer drives
// per-phase good/bad words, a monitor checks sweep ordering every cycle,
// and each sweep's results are compared with a run-length window model.
module tb_miso_phase_calibrator;

    localparam int N = 10;
    localparam int F = 8;
    localparam int S = 4;
    localparam logic [31:0] EXP_W = 32'hA5C3_0F1E;
`ifdef PHASE_CAL_DUALWORD_EN
    localparam logic [31:0] CMP_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] CMP_MASK = 32'h0000_FFFF;
`endif

    logic         dataclk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cal_start = 1'b0;
    logic         auto_mode = 1'b1;
    logic [3:0]   manual_phase = 4'd0;
    logic         frame_ack = 1'b0;
    logic [31:0]  miso_word = 32'd0;
    logic [31:0]  expected_word = EXP_W;
    logic         frame_req, busy, cal_done, cal_fail;
    logic [3:0]   phase_select;
    logic [N-1:0] pass_map;

    int checks = 0;
    int failures = 0;

    // Sequencer configuration and state
    logic [N-1:0] seq_pat = '0;
    logic [31:0]  seq_corrupt = 32'd0;
    bit           seq_last_only = 1'b0;
    int           seq_lat = 0;
    bit           seq_stray = 1'b0;
    int           seq_lat_cnt = 0;
    int           seq_frm = 0;
    logic [3:0]   seq_ph = 4'd0;
    bit           seq_toggle = 1'b0;

    // Monitor state
    bit           mon_prev_busy = 1'b0;
    bit           mon_prev_req = 1'b0;
    logic [3:0]   mon_prev_ps = 4'd0;
    int           mon_since = 0;
    bit           mon_first_req = 1'b0;
    int           hs [N];

    int           model_cal = 0;

    always #5 dataclk = ~dataclk;

    miso_phase_calibrator dut (
        .dataclk_i       (dataclk),
        .reset_n_i       (reset_n),
        .cal_start_i     (cal_start),
        .auto_mode_i     (auto_mode),
        .manual_phase_i  (manual_phase),
        .frame_req_o     (frame_req),
        .frame_ack_i     (frame_ack),
        .miso_word_i     (miso_word),
        .expected_word_i (expected_word),
        .phase_select_o  (phase_select),
        .busy_o          (busy),
        .cal_done_o      (cal_done),
        .cal_fail_o      (cal_fail),
        .pass_map_o      (pass_map)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Longest run of ones, lowest start on ties, centre rounded down.
    function automatic void model_best(input logic [N-1:0] m, output bit found, output int mid);
        int bl = 0;
        int bs = 0;
        for (int s = 0; s < N; s++) begin
            int l = 0;
            while (s + l < N && m[s + l]) l++;
            if (l > bl) begin
                bl = l;
                bs = s;
            end
        end
        found = (bl > 0);
        mid = bs + (bl - 1) / 2;
    endfunction

    // Frame sequencer: acks frame_req after seq_lat cycles with a word that
    // is good or corrupted according to the phase pattern.
    initial begin
        forever begin
            @(posedge dataclk);
            #1;
            frame_ack = 1'b0;
            if (!reset_n) begin
                seq_lat_cnt = 0;
                seq_frm = 0;
            end else begin
                if (!busy || phase_select != seq_ph) begin
                    seq_ph = phase_select;
                    seq_frm = 0;
                end
                if (frame_req) begin
                    if (seq_lat_cnt >= seq_lat) begin
                        frame_ack = 1'b1;
                        if (seq_pat[phase_select] || (seq_last_only && seq_frm != F - 1))
                            miso_word = EXP_W;
                        else
                            miso_word = EXP_W ^ seq_corrupt;
                        seq_frm++;
                        seq_lat_cnt = 0;
                    end else begin
                        seq_lat_cnt++;
                    end
                end else if (seq_stray && busy) begin
                    seq_toggle = !seq_toggle;
                    if (seq_toggle) begin
                        frame_ack = 1'b1;
                        miso_word = ~EXP_W;
                    end
                end
            end
        end
    end

    // Per-cycle monitor: sweeps start at phase 0, step by one, settle for
    // exactly S cycles before the first request, and request only when busy.
    initial begin
        forever begin
            @(negedge dataclk);
            if (!reset_n) begin
                mon_prev_busy = 1'b0;
                mon_prev_req = 1'b0;
                mon_prev_ps = 4'd0;
                mon_since = 0;
                mon_first_req = 1'b0;
            end else begin
                if (busy && !mon_prev_busy) begin
                    chk("sweep_start_phase", phase_select, 0);
                    mon_since = 0;
                    mon_first_req = 1'b1;
                end else if (busy && phase_select != mon_prev_ps) begin
                    chk("phase_step", phase_select, mon_prev_ps + 1);
                    mon_since = 0;
                    mon_first_req = 1'b1;
                end else begin
                    mon_since++;
                end
                if (frame_req) chk("req_only_when_busy", busy, 1);
                if (frame_req && !mon_prev_req && mon_first_req) begin
                    chk("settle_cycles", mon_since, S);
                    mon_first_req = 1'b0;
                end
                if (frame_req && frame_ack && phase_select < N) hs[phase_select]++;
                mon_prev_busy = busy;
                mon_prev_req = frame_req;
                mon_prev_ps = phase_select;
            end
        end
    end

    task automatic run_sweep(input logic [N-1:0] pat, input logic [31:0] corrupt,
                             input bit last_only, input int lat, input bit stray,
                             input bit mid_start);
        logic [N-1:0] exp_map;
        bit found;
        int best;
        bit got;
        bit pulsed;
        seq_pat = pat;
        seq_corrupt = corrupt;
        seq_last_only = last_only;
        seq_lat = lat;
        seq_stray = stray;
        for (int p = 0; p < N; p++) begin
            hs[p] = 0;
            exp_map[p] = pat[p] || ((corrupt & CMP_MASK) == 32'd0);
        end
        model_best(exp_map, found, best);
        @(negedge dataclk);
        cal_start = 1'b1;
        @(negedge dataclk);
        cal_start = 1'b0;
        got = 1'b0;
        pulsed = 1'b0;
        for (int c = 0; c < 4000 && !got; c++) begin
            @(negedge dataclk);
            cal_start = 1'b0;
            if (cal_done && !busy) got = 1'b1;
            else if (mid_start && !pulsed && busy && phase_select == 4'd2) begin
                cal_start = 1'b1;
                pulsed = 1'b1;
            end
        end
        cal_start = 1'b0;
        seq_stray = 1'b0;
        chk("sweep_completes", got, 1);
        if (found) model_cal = best;
        chk("pass_map_model", pass_map, exp_map);
        chk("cal_fail_model", cal_fail, !found);
        chk("busy_after_sweep", busy, 0);
        chk("phase_select_model", phase_select, auto_mode ? model_cal : manual_phase);
        for (int p = 0; p < N; p++) chk($sformatf("frames_phase%0d", p), hs[p], F);
        repeat (3) @(negedge dataclk);
        chk("cal_done_held", cal_done, 1);
    endtask

    initial begin
        bit reached;
        reset_n = 1'b0;
        repeat (3) @(negedge dataclk);
        chk("rst_frame_req", frame_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cal_done", cal_done, 0);
        chk("rst_cal_fail", cal_fail, 0);
        chk("rst_pass_map", pass_map, 0);
        chk("rst_phase_select", phase_select, 0);
        reset_n = 1'b1;
        @(negedge dataclk);

        run_sweep(10'h0F8, 32'h0000_0001, 1'b0, 0, 1'b0, 1'b0);
        chk("lit_map_0F8", pass_map, 10'h0F8);
        chk("lit_ps_5", phase_select, 5);
        chk("lit_fail_0", cal_fail, 0);
        chk("lit_done_1", cal_done, 1);

        run_sweep(10'h000, 32'h0000_0100, 1'b0, 1, 1'b0, 1'b0);
        chk("lit_nopass_fail", cal_fail, 1);
        chk("lit_nopass_keep5", phase_select, 5);

        run_sweep(10'h1F3, 32'h0000_8000, 1'b0, 2, 1'b0, 1'b0);
        chk("lit_map_1F3", pass_map, 10'h1F3);
        chk("lit_ps_6", phase_select, 6);

        run_sweep(10'h066, 32'h0000_0010, 1'b1, 1, 1'b0, 1'b0);
        chk("lit_tie_map", pass_map, 10'h066);
        chk("lit_tie_ps_1", phase_select, 1);

        // Reset while requesting a frame at phase 4
        seq_pat = 10'h3FF;
        seq_corrupt = 32'h1;
        seq_last_only = 1'b0;
        seq_lat = 1;
        @(negedge dataclk);
        cal_start = 1'b1;
        @(negedge dataclk);
        cal_start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 2000 && !reached; c++) begin
            @(negedge dataclk);
            if (busy && frame_req && phase_select == 4'd4) reached = 1'b1;
        end
        chk("reach_req_phase4", reached, 1);
        reset_n = 1'b0;
        model_cal = 0;
        @(posedge dataclk);
        #1;
        chk("midrst_frame_req", frame_req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_phase_select", phase_select, 0);
        chk("midrst_pass_map", pass_map, 0);
        chk("midrst_cal_done", cal_done, 0);
        @(negedge dataclk);
        reset_n = 1'b1;
        run_sweep(10'h3FF, 32'h0000_0001, 1'b0, 0, 1'b0, 1'b0);
        chk("lit_all_map", pass_map, 10'h3FF);
        chk("lit_all_ps_4", phase_select, 4);

        // Chip A corrupted at every phase
        run_sweep(10'h000, 32'hFFFF_0000, 1'b0, 1, 1'b0, 1'b0);
`ifdef PHASE_CAL_DUALWORD_EN
        chk("lit_upper_fail", cal_fail, 1);
        chk("lit_upper_map", pass_map, 10'h000);
`else
        chk("lit_upper_map", pass_map, 10'h3FF);
        chk("lit_upper_fail", cal_fail, 0);
`endif
        chk("lit_upper_ps_4", phase_select, 4);

        // Manual phase takes effect one cycle after the input changes
        @(posedge dataclk);
        #1;
        auto_mode = 1'b0;
        manual_phase = 4'd7;
        chk("manual_not_yet", phase_select, 4);
        @(posedge dataclk);
        #1;
        chk("lit_manual_7", phase_select, 7);

        // Sweep with stray acks outside REQ and a cal_start while busy
        run_sweep(10'h3FF, 32'h0000_0001, 1'b0, 1, 1'b1, 1'b1);
        chk("lit_stray_map", pass_map, 10'h3FF);
        chk("lit_stray_ps_manual", phase_select, 7);

        @(posedge dataclk);
        #1;
        manual_phase = 4'd3;
        @(posedge dataclk);
        #1;
        chk("lit_manual_3", phase_select, 3);
        auto_mode = 1'b1;
        @(posedge dataclk);
        #1;
        chk("lit_auto_back_4", phase_select, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
